ariane_bm_crc: RTL and testbench

ARIANE_BM_CRC -- requirements
Module: ariane_bm_crc

---
 rtl/ariane_bitmanip_pkg.sv | 29 ++
 rtl/ariane_bm_crc_step.sv | 10 +
 rtl/ariane_bm_crc.sv | 95 +++++++++
 tb/tb_ariane_bm_crc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_bitmanip_pkg.sv
// Shared bit-manipulation definitions: CRC polynomials, BM_FUNC CRC codes and
// the CRC unit state type.
package ariane_bitmanip_pkg;

    localparam logic [31:0] BM_CRC32_POLY  = 32'hEDB88320;
    localparam logic [31:0] BM_CRC32C_POLY = 32'h82F63B78;

    // bit2 selects Castagnoli, bits1:0 select b/h/w/d
    localparam logic [8:0] BM_FUNC_CRC32_B  = 9'h000;
    localparam logic [8:0] BM_FUNC_CRC32_H  = 9'h001;
    localparam logic [8:0] BM_FUNC_CRC32_W  = 9'h002;
    localparam logic [8:0] BM_FUNC_CRC32_D  = 9'h003;
    localparam logic [8:0] BM_FUNC_CRC32C_B = 9'h004;
    localparam logic [8:0] BM_FUNC_CRC32C_H = 9'h005;
    localparam logic [8:0] BM_FUNC_CRC32C_W = 9'h006;
    localparam logic [8:0] BM_FUNC_CRC32C_D = 9'h007;

    typedef enum logic [1:0] {
        BM_CRC_IDLE,
        BM_CRC_BUSY,
        BM_CRC_DONE
    } bm_crc_state_t;

    // Bit count for a size code: 8/16/32/64
    function automatic logic [6:0] bm_crc_bits(input logic [1:0] size);
        return 7'd8 << size;
    endfunction

endpackage

// File: rtl/ariane_bm_crc_step.sv
// One reflected CRC bit step over the full operand register.
module ariane_bm_crc_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] poly,
    output logic [XLEN-1:0] x_next
);
    assign x_next = (x >> 1) ^ (poly & {XLEN{x[0]}});
endmodule

// File: rtl/ariane_bm_crc.sv
// Iterative CRC32/CRC32C unit for the bitmanip FU (IDLE -> BUSY -> DONE).
// Define ARIANE_BM_CRC_BYTEWISE_EN to process 8 bits per cycle instead of 1.
module ariane_bm_crc
    import ariane_bitmanip_pkg::*;
#(
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [8:0]               operator_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

`ifdef ARIANE_BM_CRC_BYTEWISE_EN
    localparam int STEPS = 8;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [6:0] STEP_INC = 7'(STEPS);

    bm_crc_state_t            state;
    logic [6:0]               cnt;
    logic [6:0]               n_q;
    logic [XLEN-1:0]          x_q;
    logic [XLEN-1:0]          poly_q;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic [6:0]               cnt_next;
    logic                     unused_op;

    logic [STEPS:0][XLEN-1:0] chain;

    assign unused_op = ^operator_i[8:3];
    assign chain[0]  = x_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        ariane_bm_crc_step #(.XLEN(XLEN)) u_step (
            .x      (chain[g]),
            .poly   (poly_q),
            .x_next (chain[g+1])
        );
    end

    assign cnt_next = cnt + STEP_INC;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= BM_CRC_IDLE;
            cnt    <= '0;
            n_q    <= '0;
            x_q    <= '0;
            poly_q <= '0;
            id_q   <= '0;
        end else begin
            case (state)
                BM_CRC_IDLE: begin
                    if (valid_i && !flush_i) begin
                        x_q    <= operand_a_i;
                        poly_q <= {{(XLEN-32){1'b0}},
                                   operator_i[2] ? BM_CRC32C_POLY : BM_CRC32_POLY};
                        id_q   <= trans_id_i;
                        n_q    <= bm_crc_bits(operator_i[1:0]);
                        cnt    <= '0;
                        state  <= BM_CRC_BUSY;
                    end
                end
                BM_CRC_BUSY: begin
                    if (flush_i) begin
                        state <= BM_CRC_IDLE;
                    end else begin
                        x_q <= chain[STEPS];
                        cnt <= cnt_next;
                        // exact compare: N is always a multiple of STEPS, never wraps
                        if (cnt_next == n_q) state <= BM_CRC_DONE;
                    end
                end
                BM_CRC_DONE: state <= BM_CRC_IDLE;
                default:     state <= BM_CRC_IDLE;
            endcase
        end
    end

    assign ready_o           = (state == BM_CRC_IDLE);
    assign result_valid_o    = (state == BM_CRC_DONE) && !flush_i;
    assign result_o          = (state == BM_CRC_DONE) ? x_q  : '0;
    assign result_trans_id_o = (state == BM_CRC_DONE) ? id_q : '0;

endmodule

// File: tb/tb_ariane_bm_crc.sv
// Scoreboard bench for ariane_bm_crc: expected results/IDs/due cycles queued at accept.
module tb_ariane_bm_crc;

`ifdef ARIANE_BM_CRC_BYTEWISE_EN
    localparam int SPC = 8;
`else
    localparam int SPC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [8:0]  op = '0;
    logic [63:0] opa = '0;
    logic [2:0]  tid = '0;
    logic        ready;
    logic        rvalid;
    logic [63:0] res;
    logic [2:0]  rid;

    ariane_bm_crc #(.TRANS_ID_BITS(3), .XLEN(64)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .valid_i           (valid),
        .ready_o           (ready),
        .operator_i        (op),
        .operand_a_i       (opa),
        .trans_id_i        (tid),
        .result_o          (res),
        .result_valid_o    (rvalid),
        .result_trans_id_o (rid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  id;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic int iters(input logic [8:0] o);
        return (8 << o[1:0]) / SPC;
    endfunction

    function automatic logic [63:0] model(input logic [8:0] o, input logic [63:0] a);
        logic [63:0] x;
        logic [63:0] p;
        x = a;
        p = o[2] ? 64'h82F63B78 : 64'hEDB88320;
        for (int i = 0; i < (8 << o[1:0]); i++)
            x = (x >> 1) ^ (x[0] ? p : 64'h0);
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result got id=%0d res=%h, required no strobe", rid, res);
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (res !== mon_e.res) begin
                        errors++;
                        $display("FAIL result got %h required %h", res, mon_e.res);
                    end
                    checks++;
                    if (rid !== mon_e.id) begin
                        errors++;
                        $display("FAIL trans_id got %0d required %0d", rid, mon_e.id);
                    end
                    checks++;
                    if (cyc !== mon_e.due) begin
                        errors++;
                        $display("FAIL latency got cycle %0d required %0d", cyc, mon_e.due);
                    end
                end
            end else begin
                checks++;
                if (res !== 64'h0 || rid !== 3'h0) begin
                    errors++;
                    $display("FAIL idle_outputs got res=%h id=%0d required 0/0", res, rid);
                end
            end
        end
    end

    // Drive a request and wait for accept; returns the accept cycle (or -1).
    task automatic issue(input logic [8:0] o, input logic [63:0] a, input logic [2:0] id,
                         input logic [63:0] exp_res, input bit push, output int t);
        @(negedge clk);
        op = o; opa = a; tid = id; valid = 1'b1;
        for (int k = 0; k < 300 && !ready; k++) @(negedge clk);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got ready=%b required 1", ready);
            valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        if (push) sb.push_back('{exp_res, id, t + iters(o) + 1});
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", ready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", rvalid); end
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL reset_result got %h required 0", res); end
        checks++; if (rid !== 3'h0) begin errors++; $display("FAIL reset_id got %0d required 0", rid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        int t;
        issue(9'h000, 64'h80, 3'd1, 64'h00000000EDB88320, 1'b1, t);
        drain();
        issue(9'h004, 64'h80, 3'd3, 64'h0000000082F63B78, 1'b1, t);
        drain();
        issue(9'h001, 64'h8000, 3'd4, 64'h00000000EDB88320, 1'b1, t);
        drain();
        issue(9'h003, 64'h8000000000000000, 3'd5, 64'h00000000EDB88320, 1'b1, t);
        for (int i = 0; i < iters(9'h003); i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready cycle %0d got %b required 0", i, ready);
            end
        end
        drain();
    endtask

    task automatic test_random();
        int t;
        logic [8:0]  o;
        logic [63:0] a;
        for (int i = 0; i < 8; i++) begin
            o = {6'($urandom), 3'($urandom)};
            a = {$urandom, $urandom};
            issue(o, a, 3'($urandom), model(o, a), 1'b1, t);
            drain();
        end
    endtask

    task automatic test_flush();
        int t;
        issue(9'h003, {$urandom, $urandom}, 3'd6, 64'h0, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b required 1", ready); end
        issue(9'h002, 64'h80000000, 3'd2, 64'h00000000EDB88320, 1'b1, t);
        drain();
    endtask

    task automatic test_async_reset();
        int t;
        issue(9'h003, {$urandom, $urandom}, 3'd7, 64'h0, 1'b0, t);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b required 1", ready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b required 0", rvalid); end
        checks++; if (res !== 64'h0) begin errors++; $display("FAIL arst_result got %h required 0", res); end
        checks++; if (rid !== 3'h0) begin errors++; $display("FAIL arst_id got %0d required 0", rid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        @(negedge clk);
        op = 9'h000; opa = 64'h80; tid = 3'd1; valid = 1'b1;
        for (int k = 0; k < 300 && !ready; k++) @(negedge clk);
        t1 = cyc;
        sb.push_back('{64'h00000000EDB88320, 3'd1, t1 + iters(9'h000) + 1});
        @(posedge clk);
        #1 op = 9'h004; tid = 3'd2;
        @(negedge clk);
        for (int k = 0; k < 300 && !ready; k++) @(negedge clk);
        t2 = cyc;
        checks++;
        if (t2 !== t1 + iters(9'h000) + 2) begin
            errors++;
            $display("FAIL b2b_accept got cycle %0d required %0d", t2, t1 + iters(9'h000) + 2);
        end
        sb.push_back('{64'h0000000082F63B78, 3'd2, t2 + iters(9'h004) + 1});
        @(posedge clk);
        #1 valid = 1'b0;
        drain();
        @(negedge clk);
        op = 9'h000; opa = 64'h80; tid = 3'd3; valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL flush_idle_accept got ready=%b required 1", ready); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
